// File: rtl/flag_pkg.sv
// ---------------------------------------------------------------------------
// flag_pkg
// Shared constants and types for the interrupt flag sequencer.
//   - Flag bit positions inside the flag-register output word.
//   - Flag-register opcodes this block emits on its own behalf.
//   - LDFI selector that addresses the interrupt-enable flag.
//   - State encoding for the flag_ctrl sequencer.
// ---------------------------------------------------------------------------
package flag_pkg;

    localparam int FZ = 0;
    localparam int FO = 1;
    localparam int FN = 2;
    localparam int FC = 3;
    localparam int FI = 4;
    localparam int FA = 5;

    localparam logic [4:0] OP_LDFI = 5'h19;
    localparam logic [4:0] OP_MOVF = 5'h1A;
    localparam logic [4:0] OP_NOP  = 5'h1F;

    localparam logic [2:0] SEL_I = 3'h4;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        CLRI,
        ACK,
        RESTORE
    } fc_state_t;

endpackage

// File: rtl/flag_stack.sv
// ---------------------------------------------------------------------------
// flag_stack
// DEPTH-entry, 8-bit wide LIFO holding flag words saved on interrupt entry.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   push_i, data_i  write data_i at the current top and grow by one
//   pop_i           shrink by one (top_o is valid before the pop)
//   top_o           most recently pushed word
//   full_o, empty_o occupancy status; push when full / pop when empty are ignored
// ---------------------------------------------------------------------------
module flag_stack #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] top_o,
    output logic       full_o,
    output logic       empty_o
);

    // One extra pointer bit lets "full" (sp == DEPTH) be told apart from "empty".
    localparam int SPW = $clog2(DEPTH) + 1;
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-2:0] IDX_ONE = (SPW-1)'(1);

    logic [7:0]     mem_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-2:0] topIdx;

    // Only the low bits address storage; at sp == DEPTH they wrap to 0 and
    // the subtraction lands on the last slot, which is the correct top.
    assign topIdx  = sp_q[SPW-2:0] - IDX_ONE;
    assign top_o   = mem_q[topIdx];
    assign full_o  = (sp_q == SP_FULL);
    assign empty_o = (sp_q == '0);

    // Pointer and storage update; the guards keep sp from ever wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[sp_q[SPW-2:0]] <= data_i;
            sp_q                 <= sp_q + SP_ONE;
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SP_ONE;
        end
    end

endmodule

// File: rtl/flag_ctrl.sv
// ---------------------------------------------------------------------------
// flag_ctrl
// Interrupt entry/return sequencer sitting in front of the flag register.
// In IDLE it forwards the decoder's flag-register controls untouched. On an
// accepted interrupt it saves the flags (SAVE), clears I with LDFI (CLRI) and
// acknowledges (ACK). On RETI it writes the saved word back with MOVF.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dec_i/dec_s/dec_val/dec_f  decoder controls for the flag register
//   reti, irq                  return-from-interrupt strobe, level request
//   q                          current flag-register contents
//   fr_i/fr_s/fr_val/fr_f      controls actually sent to the flag register
//   stall                      freeze fetch/decode while the sequencer runs
//   irq_ack                    one-cycle pulse when the interrupt is taken
//   err                        one-cycle pulse on blocked irq or empty RETI
// ---------------------------------------------------------------------------
module flag_ctrl
    import flag_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] dec_i,
    input  logic [2:0] dec_s,
    input  logic       dec_val,
    input  logic [7:0] dec_f,
    input  logic       reti,
    input  logic       irq,
    input  logic [7:0] q,
    output logic [4:0] fr_i,
    output logic [2:0] fr_s,
    output logic       fr_val,
    output logic [7:0] fr_f,
    output logic       stall,
    output logic       irq_ack,
    output logic       err
);

    fc_state_t  state_q, state_d;
    logic       err_q, err_d;
    logic [7:0] stackTop;
    logic       stackFull;
    logic       stackEmpty;

    flag_stack #(.DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (state_q == SAVE),
        .pop_i   (state_q == RESTORE),
        .data_i  (q),
        .top_o   (stackTop),
        .full_o  (stackFull),
        .empty_o (stackEmpty)
    );

    // State and error-pulse registers; reset drops stall immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next state. Only IDLE samples reti/irq, and reti takes priority so a
    // simultaneous irq is simply seen again once the return has completed.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (reti) begin
                    if (!stackEmpty) state_d = RESTORE;
                    else             err_d   = 1'b1;
                end else if (irq && q[FI]) begin
                    if (!stackFull) state_d = SAVE;
                    else            err_d   = 1'b1;
                end
            end
            SAVE:    state_d = CLRI;
            CLRI:    state_d = ACK;
            ACK:     state_d = IDLE;
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output mux. Outside IDLE the decoder is ignored and NOP keeps the flags
    // steady, except in CLRI (clear I) and RESTORE (reload saved word).
    always_comb begin
        fr_i    = OP_NOP;
        fr_s    = 3'h0;
        fr_val  = 1'b0;
        fr_f    = 8'h00;
        stall   = 1'b1;
        irq_ack = 1'b0;
        case (state_q)
            IDLE: begin
                fr_i   = dec_i;
                fr_s   = dec_s;
                fr_val = dec_val;
                fr_f   = dec_f;
                stall  = 1'b0;
            end
            CLRI: begin
                fr_i = OP_LDFI;
                fr_s = SEL_I;
            end
            ACK: begin
                irq_ack = 1'b1;
            end
            RESTORE: begin
                fr_i = OP_MOVF;
                fr_f = stackTop;
            end
            default: begin
            end
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flag_ctrl
// Self-checking bench for flag_ctrl: passthrough vector table, hand-written
// entry/return/nesting/priority/reset sequences, then randomized traffic
// compared against a queue-based model of the save/restore behaviour.
// ---------------------------------------------------------------------------
module tb_flag_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] dec_i;
    logic [2:0] dec_s;
    logic       dec_val;
    logic [7:0] dec_f;
    logic       reti;
    logic       irq;
    logic [7:0] q;
    logic [4:0] fr_i;
    logic [2:0] fr_s;
    logic       fr_val;
    logic [7:0] fr_f;
    logic       stall;
    logic       irq_ack;
    logic       err;
    logic [19:0] actual;

    int checks   = 0;
    int failures = 0;

    flag_ctrl #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .dec_i   (dec_i),
        .dec_s   (dec_s),
        .dec_val (dec_val),
        .dec_f   (dec_f),
        .reti    (reti),
        .irq     (irq),
        .q       (q),
        .fr_i    (fr_i),
        .fr_s    (fr_s),
        .fr_val  (fr_val),
        .fr_f    (fr_f),
        .stall   (stall),
        .irq_ack (irq_ack),
        .err     (err)
    );

    always #5 clk = ~clk;

    assign actual = {fr_i, fr_s, fr_val, fr_f, stall, irq_ack, err};

    typedef struct {
        logic [4:0]  di;
        logic [2:0]  ds;
        logic        dv;
        logic [7:0]  df;
        logic [19:0] expv;
    } vec_t;

    // Packs the expected outputs in the same order as 'actual'.
    function automatic logic [19:0] ex(input logic [4:0] i, input logic [2:0] s,
                                       input logic v, input logic [7:0] f,
                                       input logic st, input logic ak, input logic er);
        return {i, s, v, f, st, ak, er};
    endfunction

    task automatic checkOutput(input string name, input logic [19:0] act, input logic [19:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drives inputs just after the falling edge and lets them settle.
    task automatic applyStimulus(input logic [4:0] di, input logic [2:0] ds, input logic dv,
                                 input logic [7:0] df, input logic rt, input logic ir,
                                 input logic [7:0] qq);
        @(negedge clk);
        dec_i   = di;
        dec_s   = ds;
        dec_val = dv;
        dec_f   = df;
        reti    = rt;
        irq     = ir;
        q       = qq;
        #1;
    endtask

    // Fixed decoder fields used by the hand-written sequences.
    localparam logic [4:0] D_I = 5'h03;
    localparam logic [2:0] D_S = 3'h2;
    localparam logic       D_V = 1'b1;
    localparam logic [7:0] D_F = 8'hA5;

    function automatic logic [19:0] pt(input logic er);
        return ex(D_I, D_S, D_V, D_F, 1'b0, 1'b0, er);
    endfunction

    task automatic step(input logic rt, input logic ir, input logic [7:0] qq);
        applyStimulus(D_I, D_S, D_V, D_F, rt, ir, qq);
    endtask

    task automatic checkSp(input string name, input int expSp);
        checkOutput(name, 20'(dut.u_stack.sp_q), 20'(expSp));
    endtask

    // One complete accepted entry starting from IDLE with flag word qq.
    task automatic doEntry(input string tag, input logic [7:0] qq);
        step(1'b0, 1'b1, qq);
        checkOutput({tag, "_idle"}, actual, pt(1'b0));
        step(1'b0, 1'b0, qq);
        checkOutput({tag, "_save"}, actual, ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, qq);
        checkOutput({tag, "_clri"}, actual, ex(5'h19, 3'h4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, qq);
        checkOutput({tag, "_ack"}, actual, ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [6];
        int          pending [$];
        logic [7:0]  saved [$];
        logic        errExp;
        logic        errNext;
        logic [19:0] expv;
        logic [4:0]  ri;
        logic [2:0]  rs;
        logic        rv, rt, ir;
        logic [7:0]  rf, rq;
        logic [7:0]  lvlQ;
        int          code;

        reset = 1'b1;
        dec_i = '0; dec_s = '0; dec_val = 1'b0; dec_f = '0;
        reti = 1'b0; irq = 1'b0; q = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs", actual, ex(5'h00, 3'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        checkSp("reset_sp", 0);
        reset = 1'b0;

        // Passthrough table: IDLE forwards decoder fields in the same cycle.
        vecs[0] = '{5'h00, 3'h0, 1'b0, 8'h0D, 20'h0000D << 3};
        vecs[1] = '{5'h19, 3'h4, 1'b0, 8'hFF, ex(5'h19, 3'h4, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0)};
        vecs[2] = '{5'h1A, 3'h0, 1'b0, 8'h31, ex(5'h1A, 3'h0, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0)};
        vecs[3] = '{5'h1F, 3'h0, 1'b0, 8'h00, ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0)};
        vecs[4] = '{5'h0A, 3'h7, 1'b1, 8'h80, ex(5'h0A, 3'h7, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0)};
        vecs[5] = '{5'h05, 3'h3, 1'b1, 8'h5A, ex(5'h05, 3'h3, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0)};
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].di, vecs[k].ds, vecs[k].dv, vecs[k].df, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("passthrough_%0d", k), actual, vecs[k].expv);
        end

        // Entry with A,I,Z set, then return while q shows the handler's flags.
        doEntry("entry", 8'h31);
        step(1'b0, 1'b0, 8'h21);
        checkOutput("entry_done", actual, pt(1'b0));
        checkSp("entry_sp", 1);
        checkOutput("entry_stack0", 20'(dut.u_stack.mem_q[0]), 20'h00031);
        step(1'b1, 1'b0, 8'h24);
        checkOutput("reti_idle", actual, pt(1'b0));
        step(1'b0, 1'b0, 8'h24);
        checkOutput("restore", actual, ex(5'h1A, 3'h0, 1'b0, 8'h31, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 8'h31);
        checkOutput("restore_done", actual, pt(1'b0));
        checkSp("restore_sp", 0);

        // RETI with nothing saved: one-cycle error, no stall.
        step(1'b1, 1'b0, 8'h31);
        checkOutput("underflow_idle", actual, pt(1'b0));
        step(1'b0, 1'b0, 8'h31);
        checkOutput("underflow_err", actual, pt(1'b1));
        step(1'b0, 1'b0, 8'h31);
        checkOutput("underflow_clear", actual, pt(1'b0));

        // Masked request (I clear) is ignored.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'h20);
            checkOutput($sformatf("masked_%0d", k), actual, pt(1'b0));
        end
        checkSp("masked_sp", 0);

        // Nest to full, overflow attempt, then unwind in LIFO order.
        for (int lvl = 0; lvl < DEPTH; lvl++) begin
            lvlQ = 8'h30 | 8'(lvl);
            doEntry($sformatf("nest%0d", lvl), lvlQ);
        end
        checkSp("nest_sp_full", DEPTH);
        step(1'b0, 1'b1, 8'h3F);
        checkOutput("ovf_idle", actual, pt(1'b0));
        step(1'b0, 1'b0, 8'h3F);
        checkOutput("ovf_err", actual, pt(1'b1));
        step(1'b0, 1'b0, 8'h3F);
        checkOutput("ovf_noentry", actual, pt(1'b0));
        checkSp("ovf_sp", DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            lvlQ = 8'h30 | 8'(DEPTH - 1 - k);
            step(1'b1, 1'b0, 8'h20);
            checkOutput($sformatf("unwind%0d_idle", k), actual, pt(1'b0));
            step(1'b0, 1'b0, 8'h20);
            checkOutput($sformatf("unwind%0d_restore", k), actual,
                        ex(5'h1A, 3'h0, 1'b0, lvlQ, 1'b1, 1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 8'h20);
        checkSp("unwind_sp", 0);

        // reti and irq together: restore first, entry on the next IDLE cycle.
        doEntry("prio_pre", 8'h31);
        step(1'b1, 1'b1, 8'h35);
        checkOutput("prio_idle", actual, pt(1'b0));
        step(1'b0, 1'b1, 8'h35);
        checkOutput("prio_restore", actual, ex(5'h1A, 3'h0, 1'b0, 8'h31, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 8'h35);
        checkOutput("prio_reidle", actual, pt(1'b0));
        step(1'b0, 1'b0, 8'h35);
        checkOutput("prio_save", actual, ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 8'h35);
        step(1'b0, 1'b0, 8'h35);
        checkOutput("prio_ack", actual, ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
        step(1'b0, 1'b0, 8'h25);
        checkSp("prio_sp", 1);

        // Reset during CLRI: stall drops at once and the stack is emptied.
        step(1'b0, 1'b1, 8'h33);
        step(1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b0, 8'h33);
        checkOutput("rst_clri", actual, ex(5'h19, 3'h4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async", actual, pt(1'b0));
        checkSp("rst_sp", 0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the queue model.
        errExp = 1'b0;
        for (int n = 0; n < 600; n++) begin
            ri = 5'($urandom);
            rs = 3'($urandom);
            rv = 1'($urandom);
            rf = 8'($urandom);
            rq = 8'($urandom);
            rt = ($urandom_range(0, 7) == 0);
            ir = 1'($urandom_range(0, 1));
            applyStimulus(ri, rs, rv, rf, rt, ir, rq);

            if (pending.size() == 0) begin
                expv = ex(ri, rs, rv, rf, 1'b0, 1'b0, errExp);
            end else begin
                case (pending[0])
                    2:       expv = ex(5'h19, 3'h4, 1'b0, 8'h00, 1'b1, 1'b0, errExp);
                    3:       expv = ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b1, 1'b1, errExp);
                    4:       expv = ex(5'h1A, 3'h0, 1'b0, saved[$], 1'b1, 1'b0, errExp);
                    default: expv = ex(5'h1F, 3'h0, 1'b0, 8'h00, 1'b1, 1'b0, errExp);
                endcase
            end
            checkOutput($sformatf("random_%0d", n), actual, expv);

            errNext = 1'b0;
            if (pending.size() != 0) begin
                code = pending.pop_front();
                if (code == 1) saved.push_back(rq);
                if (code == 4) void'(saved.pop_back());
            end else if (rt) begin
                if (saved.size() > 0) pending.push_back(4);
                else                  errNext = 1'b1;
            end else if (ir && rq[4]) begin
                if (saved.size() < DEPTH) pending = {1, 2, 3};
                else                      errNext = 1'b1;
            end
            errExp = errNext;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
